// File: rtl/mvu_job_scheduler_if.sv
// Request, MVU start/done and status signals of the MVU job scheduler.
// master = job source / MVU side, slave = scheduler.
interface mvu_job_scheduler_if #(
    parameter int unsigned NMVU    = 8,
    parameter int unsigned BMVUA   = 3,
    parameter int unsigned BCNTDWN = 29,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned QW = $clog2(DEPTH) + 1;

    logic               req_valid;
    logic               req_ready;
    logic [BMVUA-1:0]   req_mvu;
    logic [BCNTDWN-1:0] req_countdown;
    logic [NMVU-1:0]    mvu_done;
    logic [NMVU-1:0]    start;
    logic [BCNTDWN-1:0] cmd_countdown;
    logic [NMVU-1:0]    busy;
    logic [QW-1:0]      q_count;
    logic [NMVU-1:0]    timeout;
    logic [NMVU-1:0]    timeout_clr;

    modport master (
        output req_valid, req_mvu, req_countdown, mvu_done, timeout_clr,
        input  req_ready, start, cmd_countdown, busy, q_count, timeout
    );

    modport slave (
        input  req_valid, req_mvu, req_countdown, mvu_done, timeout_clr,
        output req_ready, start, cmd_countdown, busy, q_count, timeout
    );
endinterface

// File: rtl/mvu_job_scheduler.sv
// Age-ordered job queue issuing one job per cycle to idle MVUs, strict order per MVU.
// Optional per-MVU watchdog compiled in when MVU_SCHED_WATCHDOG_EN is defined.
module mvu_job_scheduler #(
    parameter int unsigned NMVU    = 8,
    parameter int unsigned BMVUA   = 3,
    parameter int unsigned BCNTDWN = 29,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                rst,
    mvu_job_scheduler_if.slave  bus
);
    localparam int unsigned QW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [BMVUA-1:0]   mvu;
        logic [BCNTDWN-1:0] countdown;
    } job_t;

    job_t               queue_q  [DEPTH];
    job_t               queue_nx [DEPTH];
    logic [QW-1:0]      count_q;
    logic [QW-1:0]      count_nx;
    logic               ready_q;
    logic [NMVU-1:0]    busy_q;
    logic [NMVU-1:0]    busy_nx;
    logic [NMVU-1:0]    start_q;
    logic [NMVU-1:0]    start_nx;
    logic [BCNTDWN-1:0] cmd_q;
    logic [NMVU-1:0]    timeout_q;
    logic [NMVU-1:0]    wd_fire;
    logic [DEPTH-1:0]   elig;
    logic               sel_found;
    logic [SW-1:0]      sel_idx;
    job_t               sel_job;
    logic               accept;

    // ready_q always mirrors count_q < DEPTH, so no same-cycle issue credit
    assign accept = bus.req_valid && ready_q;

    // Oldest eligible entry: its MVU is idle and no older entry targets that MVU
    always_comb begin
        elig      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_job   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            elig[i] = (QW'(i) < count_q) && !busy_q[queue_q[i].mvu];
            for (int unsigned j = 0; j < i; j++) begin
                if (queue_q[j].mvu == queue_q[i].mvu) begin
                    elig[i] = 1'b0;
                end
            end
            if (elig[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = SW'(i);
                sel_job   = queue_q[i];
            end
        end
    end

    always_comb begin
        start_nx = '0;
        if (sel_found) begin
            start_nx[sel_job.mvu] = 1'b1;
        end
    end

    // Remove the issued entry by compacting, then append any new job at the tail
    always_comb begin
        queue_nx = queue_q;
        count_nx = count_q;
        if (sel_found) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                if (SW'(i) >= sel_idx) begin
                    queue_nx[i] = queue_q[i+1];
                end
            end
            count_nx = count_q - QW'(1);
        end
        if (accept) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (QW'(i) == count_nx) begin
                    queue_nx[i] = '{mvu: bus.req_mvu, countdown: bus.req_countdown};
                end
            end
            count_nx = count_nx + QW'(1);
        end
    end

    // done pulses for idle MVUs fall away naturally in the mask
    always_comb begin
        busy_nx = (busy_q & ~bus.mvu_done & ~wd_fire) | start_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
            count_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= '0;
            start_q <= '0;
            cmd_q   <= '0;
        end else begin
            queue_q <= queue_nx;
            count_q <= count_nx;
            ready_q <= (count_nx < QW'(DEPTH));
            busy_q  <= busy_nx;
            start_q <= start_nx;
            cmd_q   <= sel_found ? sel_job.countdown : '0;
        end
    end

`ifdef MVU_SCHED_WATCHDOG_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt [NMVU];

    // A done on the same edge takes precedence over the watchdog
    always_comb begin
        wd_fire = '0;
        for (int unsigned m = 0; m < NMVU; m++) begin
            wd_fire[m] = busy_q[m] && !bus.mvu_done[m] && (wd_cnt[m] == TW'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned m = 0; m < NMVU; m++) begin
                wd_cnt[m] <= '0;
            end
            timeout_q <= '0;
        end else begin
            for (int unsigned m = 0; m < NMVU; m++) begin
                if (start_nx[m]) begin
                    wd_cnt[m] <= '0;
                end else if (busy_q[m]) begin
                    wd_cnt[m] <= wd_cnt[m] + TW'(1);
                end
            end
            timeout_q <= wd_fire | (timeout_q & ~bus.timeout_clr);
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    logic unused_timeout_clr;

    assign wd_fire            = '0;
    assign timeout_q          = '0;
    assign unused_timeout_clr = ^bus.timeout_clr;
`endif

    assign bus.req_ready     = ready_q;
    assign bus.start         = start_q;
    assign bus.cmd_countdown = cmd_q;
    assign bus.busy          = busy_q;
    assign bus.q_count       = count_q;
    assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_mvu_job_scheduler.sv
// Bench for mvu_job_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_mvu_job_scheduler;
    localparam int unsigned NMVU    = 8;
    localparam int unsigned BMVUA   = 3;
    localparam int unsigned BCNTDWN = 29;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mvu_job_scheduler_if #(.NMVU(NMVU), .BMVUA(BMVUA), .BCNTDWN(BCNTDWN), .DEPTH(DEPTH)) bus ();

    mvu_job_scheduler #(
        .NMVU(NMVU), .BMVUA(BMVUA), .BCNTDWN(BCNTDWN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int unsigned        mvu;
        logic [BCNTDWN-1:0] cd;
    } mjob_t;

    mjob_t              mq[$];
    logic [NMVU-1:0]    m_busy;
    logic [NMVU-1:0]    m_to;
    logic [NMVU-1:0]    m_start;
    logic [BCNTDWN-1:0] m_cmd;
`ifdef MVU_SCHED_WATCHDOG_EN
    int unsigned        m_age [NMVU];
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: oldest job whose MVU is idle and not already claimed by an older queued job starts next
    task automatic model_step();
        logic [NMVU-1:0] b_old;
        logic [NMVU-1:0] seen;
        logic [NMVU-1:0] fire;
        logic [NMVU-1:0] iss;
        logic [NMVU-1:0] done;
        bit              can_acc;
        mjob_t           nj;
        if (rst) begin
            mq.delete();
            m_busy  = '0;
            m_to    = '0;
            m_start = '0;
            m_cmd   = '0;
`ifdef MVU_SCHED_WATCHDOG_EN
            foreach (m_age[m]) m_age[m] = 0;
`endif
            return;
        end
        b_old   = m_busy;
        done    = bus.mvu_done;
        seen    = '0;
        fire    = '0;
        iss     = '0;
        can_acc = (mq.size() < DEPTH);
        m_cmd   = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (!seen[mq[i].mvu] && !b_old[mq[i].mvu]) begin
                iss[mq[i].mvu] = 1'b1;
                m_cmd = mq[i].cd;
                mq.delete(i);
                break;
            end
            seen[mq[i].mvu] = 1'b1;
        end
        m_start = iss;
`ifdef MVU_SCHED_WATCHDOG_EN
        for (int m = 0; m < NMVU; m++) begin
            if (b_old[m] && !done[m]) begin
                m_age[m]++;
                if (m_age[m] == TIMEOUT) fire[m] = 1'b1;
            end
            if (iss[m]) m_age[m] = 0;
        end
        m_to = fire | (m_to & ~bus.timeout_clr);
`else
        m_to = '0;
`endif
        m_busy = (b_old & ~done & ~fire) | iss;
        if (bus.req_valid && can_acc) begin
            nj.mvu = int'(bus.req_mvu);
            nj.cd  = bus.req_countdown;
            mq.push_back(nj);
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            check("start", bus.start, m_start);
            check("cmd_countdown", bus.cmd_countdown, m_cmd);
            check("busy", bus.busy, m_busy);
            check("q_count", bus.q_count, mq.size());
            check("req_ready", bus.req_ready, mq.size() < DEPTH);
            check("timeout", bus.timeout, m_to);
            check("start_onehot", $countones(bus.start) <= 1, 1);
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic push(input int unsigned m, input int unsigned cd);
        bus.req_valid     = 1'b1;
        bus.req_mvu       = BMVUA'(m);
        bus.req_countdown = BCNTDWN'(cd);
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        repeat (16) begin
            bus.mvu_done = '1;
            nxt();
        end
        bus.mvu_done = '0;
        nxt();
        check("drain_q_count", bus.q_count, 0);
        check("drain_busy", bus.busy, 0);
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_mvu       = '0;
        bus.req_countdown = '0;
        bus.mvu_done      = '0;
        bus.timeout_clr   = '0;
        rst               = 1'b1;
        repeat (2) nxt();
        rst    = 1'b0;
        cmp_en = 1'b1;
        check("rst_q_count", bus.q_count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_start", bus.start, 0);
        check("rst_cmd", bus.cmd_countdown, 0);
        check("rst_ready", bus.req_ready, 1);
        check("rst_timeout", bus.timeout, 0);

        // single job: mvu 2, countdown 100
        push(2, 100);
        nxt();
        bus.req_valid = 1'b0;
        check("t1_q_count", bus.q_count, 1);
        check("t1_no_start_yet", bus.start, 0);
        nxt();
        check("t1_start", bus.start, 64'h04);
        check("t1_cmd", bus.cmd_countdown, 100);
        check("t1_busy", bus.busy, 64'h04);
        check("t1_model_start", m_start, 64'h04);
        check("t1_model_cmd", m_cmd, 100);
        nxt();
        check("t1_start_drop", bus.start, 0);
        check("t1_cmd_zero", bus.cmd_countdown, 0);
        bus.mvu_done = 8'h04;
        nxt();
        bus.mvu_done = '0;
        check("t1_busy_clr", bus.busy, 0);

        // same-MVU ordering: B waits for A's done
        push(1, 11);
        nxt();
        push(1, 22);
        nxt();
        bus.req_valid = 1'b0;
        check("t2_a_start", bus.start, 64'h02);
        check("t2_a_cmd", bus.cmd_countdown, 11);
        check("t2_q_count", bus.q_count, 1);
        repeat (3) begin
            nxt();
            check("t2_b_held", bus.start, 0);
            check("t2_b_queued", bus.q_count, 1);
        end
        bus.mvu_done = 8'h02;
        nxt();
        bus.mvu_done = '0;
        check("t2_gap", bus.start, 0);
        check("t2_busy_clr", bus.busy, 0);
        nxt();
        check("t2_b_start", bus.start, 64'h02);
        check("t2_b_cmd", bus.cmd_countdown, 22);
        check("t2_empty", bus.q_count, 0);
        bus.mvu_done = 8'h02;
        nxt();
        bus.mvu_done = '0;

        // bypass: queued (mvu1 busy) then (mvu3 idle)
        push(1, 5);
        nxt();
        push(1, 6);
        nxt();
        push(3, 7);
        nxt();
        bus.req_valid = 1'b0;
        check("t3_q_count2", bus.q_count, 2);
        check("t3_busy1", bus.busy, 64'h02);
        nxt();
        check("t3_bypass_start", bus.start, 64'h08);
        check("t3_bypass_cmd", bus.cmd_countdown, 7);
        check("t3_q_count1", bus.q_count, 1);
        check("t3_busy13", bus.busy, 64'h0a);
        check("t3_model_q", mq.size(), 1);
        nxt();
        check("t3_held", bus.start, 0);
        check("t3_remains", bus.q_count, 1);
        bus.mvu_done = 8'h0a;
        nxt();
        bus.mvu_done = '0;
        check("t3_busy_clr", bus.busy, 0);
        nxt();
        check("t3_late_start", bus.start, 64'h02);
        check("t3_late_cmd", bus.cmd_countdown, 6);
        bus.mvu_done = 8'h02;
        nxt();
        bus.mvu_done = '0;

        // full queue behind a busy MVU
        push(4, 1);
        nxt();
        for (int k = 0; k < 4; k++) begin
            push(4, 200 + k);
            nxt();
        end
        push(4, 99);
        check("t4_full_ready", bus.req_ready, 0);
        check("t4_full_count", bus.q_count, 4);
        check("t4_busy4", bus.busy, 64'h10);
        nxt();
        bus.req_valid = 1'b0;
        check("t4_no_accept", bus.q_count, 4);
        check("t4_still_full", bus.req_ready, 0);
        bus.mvu_done = 8'h10;
        nxt();
        bus.mvu_done = '0;
        check("t4_busy_clr", bus.busy, 0);
        check("t4_ready_low", bus.req_ready, 0);
        nxt();
        check("t4_issue", bus.start, 64'h10);
        check("t4_issue_cmd", bus.cmd_countdown, 200);
        check("t4_count3", bus.q_count, 3);
        check("t4_ready_back", bus.req_ready, 1);
        drain();

        // reset mid-operation
        push(5, 1);
        nxt();
        push(6, 2);
        nxt();
        push(5, 3);
        nxt();
        push(6, 4);
        nxt();
        push(5, 5);
        nxt();
        bus.req_valid = 1'b0;
        check("t5_q_count", bus.q_count, 3);
        check("t5_busy", bus.busy, 64'h60);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        check("t5_rst_count", bus.q_count, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_start", bus.start, 0);
        check("t5_rst_ready", bus.req_ready, 1);
        bus.mvu_done = 8'h60;
        nxt();
        bus.mvu_done = '0;
        check("t5_stale_done", bus.busy, 0);
        check("t5_no_start", bus.start, 0);
        nxt();
        check("t5_no_start2", bus.start, 0);

        // watchdog on mvu 0
        push(0, 3);
        nxt();
        bus.req_valid = 1'b0;
        repeat (16) nxt();
        check("t6_busy_before", bus.busy, 64'h01);
        check("t6_no_timeout", bus.timeout, 0);
        nxt();
`ifdef MVU_SCHED_WATCHDOG_EN
        check("t6_timeout", bus.timeout, 64'h01);
        check("t6_busy_cleared", bus.busy, 0);
        bus.timeout_clr = 8'h01;
        nxt();
        bus.timeout_clr = '0;
        check("t6_timeout_clr", bus.timeout, 0);
`else
        check("t6_busy_stays", bus.busy, 64'h01);
        check("t6_timeout_tied", bus.timeout, 0);
        bus.mvu_done = 8'h01;
        nxt();
        bus.mvu_done = '0;
        check("t6_done_clears", bus.busy, 0);
`endif

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid     = ($urandom_range(0, 99) < 60);
            bus.req_mvu       = BMVUA'($urandom_range(0, (c < 1500) ? 3 : NMVU - 1));
            bus.req_countdown = BCNTDWN'($urandom);
            bus.mvu_done      = ($urandom_range(0, 2) == 0) ? NMVU'($urandom) : '0;
            bus.timeout_clr   = ($urandom_range(0, 15) == 0) ? NMVU'($urandom) : '0;
            rst               = ($urandom_range(0, 299) == 0);
            nxt();
        end
        rst = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
